id_pair_packer: RTL
===================

Name: id_pair_packer

Overview:
Receive end of the ID-pair AXI-Stream produced by the Tanimoto top (M_AXIS_ID_PAIR).
- Packs the 16-bit {ref_id, cmp_id} pairs into BUS_WIDTH-bit beats for the DMA/host write path.
- Flushes a partial beat on tlast, generates tkeep, and keeps running pair/beat counters for the host.

Parameters:
BUS_WIDTH, 128, output stream width in bits (multiple of PAIR_WIDTH).
VEC_ID_WIDTH, 8, width of one vector ID.
PAIR_WIDTH, 2*VEC_ID_WIDTH, width of one ID pair (derived, not overridden).
PAIRS_PER_BEAT, BUS_WIDTH/PAIR_WIDTH, pair slots per output beat (derived; default 8).

Ports:
ap_clk  in  1  clock.
ap_rstn  in  1  asynchronous active-low reset.
S_AXIS_ID_PAIR_tdata  in  PAIR_WIDTH  {ref_id[15:8], cmp_id[7:0]}.
S_AXIS_ID_PAIR_tvalid  in  1  input pair valid.
S_AXIS_ID_PAIR_tlast  in  1  last pair of the result stream.
S_AXIS_ID_PAIR_tready  out  1  pair accepted when tvalid&&tready.
M_AXIS_DATA_tdata  out  BUS_WIDTH  packed pairs; slot k occupies [k*PAIR_WIDTH +: PAIR_WIDTH].
M_AXIS_DATA_tkeep  out  BUS_WIDTH/8  byte enables, contiguous from bit 0.
M_AXIS_DATA_tvalid  out  1  output beat valid.
M_AXIS_DATA_tlast  out  1  final beat of the stream.
M_AXIS_DATA_tready  in  1  downstream ready.
pair_count  out  32  pairs accepted since reset.
beat_count  out  32  beats emitted (handshaken) since reset.

Behaviour:
- Reset (ap_rstn low, asynchronous): all outputs 0, pack register 0, slot index 0, counters 0. Reset mid-stream discards the partial pack and any held output beat; there is no recovery of lost pairs.
- Datapath: pack register (BUS_WIDTH) plus slot index (clog2(PAIRS_PER_BEAT) bits), and one output register holding tdata/tkeep/tlast/tvalid.
- S tready = !M_tvalid || M_tready. This is a combinational path from M_tready and is intentional; it gives full throughput.
- On accept: the pair is written into pack[slot] and pair_count increments (wraps at 2^32).
- Beat completes when the accepted pair is in slot PAIRS_PER_BEAT-1, or the pair has tlast=1. On the next edge:
  - output register <= pack with the new pair merged;
  - unused upper slots are forced to 0;
  - tkeep = (2*(slot+1)) ones from bit 0;
  - tlast = input tlast;
  - M_tvalid = 1;
  - pack cleared, slot returns to 0.
- Otherwise slot increments.
- Latency: completing pair accepted at edge N -> M_tvalid high after edge N (visible cycle N+1).
- M_tvalid holds, with tdata/tkeep/tlast stable, until M_tready. On handshake beat_count increments. M_tvalid drops unless a new beat completes on the same edge, in which case the new beat loads back-to-back.
- tlast on slot PAIRS_PER_BEAT-1: a single full beat, tkeep all ones, tlast=1. No extra empty beat is emitted.
- tvalid without tlast never flushes. A partial pack waits indefinitely.
- Stall: while M_tvalid && !M_tready, S tready=0 and the pack register and slot are frozen.
- After a tlast beat the block immediately accepts a new stream. Counters are not cleared between streams.

Test Plan:
- 8 pairs 0x0100..0x0107 back-to-back, M_tready=1 -> one beat, tdata=0x0107_0106_..._0100, tkeep=0xFFFF, tlast=0, tvalid 1 cycle after the 8th accept; pair_count=8, beat_count=1.
- 3 pairs 0xA1B1,0xA2B2,0xA3B3, tlast on the 3rd -> tdata[47:0]=0xA3B3_A2B2_A1B1, upper bits 0, tkeep=0x003F, tlast=1.
- 16 pairs with M_tready held 0 for 10 cycles after the first beat -> exactly 8 accepted, S tready=0 while stalled, output stable; after release second beat follows and no pair is lost or duplicated.
- 8 pairs with tlast on the 8th -> exactly one beat, tkeep=0xFFFF, tlast=1; the next tvalid cycle starts a fresh beat at slot 0.
- Assert ap_rstn low asynchronously after 5 pairs accepted -> outputs and counters 0 immediately; then 8 new pairs yield a clean full beat with no residue.
- Random tvalid/tready (25% sparsity, 1000 pairs, tlast on the last) -> scoreboard matches every pair in order; pair_count=1000; beat_count=125; final tlast=1.

Source files
------------

// File: rtl/id_pair_packer_if.sv
// Stream bundle for id_pair_packer.
//   S_AXIS_ID_PAIR_* : input stream of {ref_id, cmp_id} pairs (PAIR_WIDTH bits).
//   M_AXIS_DATA_*    : output stream of packed BUS_WIDTH-bit beats with tkeep/tlast.
// Modport slave is the packer's view; modport master is the view of whoever drives
// the pair stream and sinks the packed beats.
interface id_pair_packer_if #(
    parameter int unsigned BUS_WIDTH    = 128,
    parameter int unsigned VEC_ID_WIDTH = 8
);
    localparam int unsigned PAIR_WIDTH = 2 * VEC_ID_WIDTH;

    logic [PAIR_WIDTH-1:0]  S_AXIS_ID_PAIR_tdata;
    logic                   S_AXIS_ID_PAIR_tvalid;
    logic                   S_AXIS_ID_PAIR_tlast;
    logic                   S_AXIS_ID_PAIR_tready;
    logic [BUS_WIDTH-1:0]   M_AXIS_DATA_tdata;
    logic [BUS_WIDTH/8-1:0] M_AXIS_DATA_tkeep;
    logic                   M_AXIS_DATA_tvalid;
    logic                   M_AXIS_DATA_tlast;
    logic                   M_AXIS_DATA_tready;

    modport slave (
        input  S_AXIS_ID_PAIR_tdata,
        input  S_AXIS_ID_PAIR_tvalid,
        input  S_AXIS_ID_PAIR_tlast,
        output S_AXIS_ID_PAIR_tready,
        output M_AXIS_DATA_tdata,
        output M_AXIS_DATA_tkeep,
        output M_AXIS_DATA_tvalid,
        output M_AXIS_DATA_tlast,
        input  M_AXIS_DATA_tready
    );

    modport master (
        output S_AXIS_ID_PAIR_tdata,
        output S_AXIS_ID_PAIR_tvalid,
        output S_AXIS_ID_PAIR_tlast,
        input  S_AXIS_ID_PAIR_tready,
        input  M_AXIS_DATA_tdata,
        input  M_AXIS_DATA_tkeep,
        input  M_AXIS_DATA_tvalid,
        input  M_AXIS_DATA_tlast,
        output M_AXIS_DATA_tready
    );
endinterface

// File: rtl/id_pair_packer.sv
// Packs 16-bit {ref_id, cmp_id} pairs into BUS_WIDTH-bit beats.
//   ap_clk, ap_rstn : clock, asynchronous active-low reset.
//   axis (slave)    : pair input stream and packed beat output stream.
//   pair_count      : pairs accepted since reset (wraps).
//   beat_count      : output beats handshaken since reset (wraps).
// A beat is emitted when the last slot fills or a pair carries tlast; partial beats
// carry contiguous tkeep from byte 0 and zeros in unused slots.
module id_pair_packer #(
    parameter int unsigned BUS_WIDTH    = 128,
    parameter int unsigned VEC_ID_WIDTH = 8
) (
    input  logic                ap_clk,
    input  logic                ap_rstn,
    id_pair_packer_if.slave     axis,
    output logic [31:0]         pair_count,
    output logic [31:0]         beat_count
);
    localparam int unsigned PAIR_WIDTH     = 2 * VEC_ID_WIDTH;
    localparam int unsigned PAIRS_PER_BEAT = BUS_WIDTH / PAIR_WIDTH;
    localparam int unsigned KEEP_WIDTH     = BUS_WIDTH / 8;
    localparam int unsigned BYTES_PER_PAIR = PAIR_WIDTH / 8;
    localparam int unsigned SLOT_W         = (PAIRS_PER_BEAT > 1) ? $clog2(PAIRS_PER_BEAT) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PAIRS_PER_BEAT - 1);

    logic [BUS_WIDTH-1:0]  pack_q, pack_d;
    logic [SLOT_W-1:0]     slot_q;
    logic [BUS_WIDTH-1:0]  data_q;
    logic [KEEP_WIDTH-1:0] keep_q, keep_d;
    logic                  last_q;
    logic                  valid_q;
    logic [31:0]           pair_cnt_q;
    logic [31:0]           beat_cnt_q;

    logic s_ready;
    logic accept;
    logic complete;
    logic m_done;

    always_comb begin
        // Combinational ready from M tready keeps full throughput on a held beat.
        s_ready  = !valid_q || axis.M_AXIS_DATA_tready;
        accept   = axis.S_AXIS_ID_PAIR_tvalid && s_ready;
        complete = accept && ((slot_q == LAST_SLOT) || axis.S_AXIS_ID_PAIR_tlast);
        m_done   = valid_q && axis.M_AXIS_DATA_tready;

        // Slots below the current one come from the pack, the current slot takes the
        // incoming pair, slots above are forced to zero.
        pack_d = '0;
        keep_d = '0;
        for (int k = 0; k < int'(PAIRS_PER_BEAT); k++) begin
            if (SLOT_W'(k) < slot_q) begin
                pack_d[k*PAIR_WIDTH +: PAIR_WIDTH] = pack_q[k*PAIR_WIDTH +: PAIR_WIDTH];
            end else if (SLOT_W'(k) == slot_q) begin
                pack_d[k*PAIR_WIDTH +: PAIR_WIDTH] = axis.S_AXIS_ID_PAIR_tdata;
            end
            if (SLOT_W'(k) <= slot_q) begin
                keep_d[k*BYTES_PER_PAIR +: BYTES_PER_PAIR] = '1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            pack_q     <= '0;
            slot_q     <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            pair_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (accept) begin
                pair_cnt_q <= pair_cnt_q + 32'd1;
            end
            if (m_done) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
            if (complete) begin
                // Loads back-to-back even when the previous beat handshakes this edge.
                data_q  <= pack_d;
                keep_q  <= keep_d;
                last_q  <= axis.S_AXIS_ID_PAIR_tlast;
                valid_q <= 1'b1;
                pack_q  <= '0;
                slot_q  <= '0;
            end else begin
                if (accept) begin
                    pack_q <= pack_d;
                    slot_q <= slot_q + SLOT_W'(1);
                end
                if (m_done) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign axis.S_AXIS_ID_PAIR_tready = s_ready;
    assign axis.M_AXIS_DATA_tdata     = data_q;
    assign axis.M_AXIS_DATA_tkeep     = keep_q;
    assign axis.M_AXIS_DATA_tlast     = last_q;
    assign axis.M_AXIS_DATA_tvalid    = valid_q;
    assign pair_count                 = pair_cnt_q;
    assign beat_count                 = beat_cnt_q;
endmodule
